// File: rtl/fpu_host_link_if.sv
// Host-side bundle/result bus plus the byte-serial FPU pins of fpu_host_link.
// master = host/FPU side (testbench), slave = the link block.
interface fpu_host_link_if #(
  parameter int unsigned TX_BYTES = 16,
  parameter int unsigned RX_BYTES = 4
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [8*TX_BYTES-1:0]   cmd_data;
  logic [7:0]              tx_byte;
  logic                    tx_active;
  logic [7:0]              rx_byte;
  logic                    rx_toggle;
  logic                    res_valid;
  logic [8*RX_BYTES-1:0]   res_data;
  logic                    busy;
  logic                    timeout;

  modport master (
    output cmd_valid, cmd_data, rx_byte, rx_toggle,
    input  cmd_ready, tx_byte, tx_active, res_valid, res_data, busy, timeout
  );

  modport slave (
    input  cmd_valid, cmd_data, rx_byte, rx_toggle,
    output cmd_ready, tx_byte, tx_active, res_valid, res_data, busy, timeout
  );
endinterface

// File: rtl/fpu_host_link.sv
// Byte-serial FPU link: ships an operand bundle MSB byte first, waits for the result
// toggle, then assembles the result. Optional WAIT timeout via FPU_LINK_TIMEOUT_EN.
module fpu_host_link #(
  parameter int unsigned TX_BYTES       = 16,
  parameter int unsigned RX_BYTES       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  fpu_host_link_if.slave bus
);
  localparam int unsigned TXW       = 8 * TX_BYTES;
  localparam int unsigned RXW       = 8 * RX_BYTES;
  localparam int unsigned MAX_BYTES = (TX_BYTES > RX_BYTES) ? TX_BYTES : RX_BYTES;
  localparam int unsigned CNT_W     = $clog2(MAX_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(TX_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(RX_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEND, ST_WAIT, ST_RECV, ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TXW-1:0]   tx_shift_q, tx_shift_d;
  logic [RXW-1:0]   rx_shift_q, rx_shift_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_active_q, tx_active_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic [RXW-1:0]   res_data_q, res_data_d;
  logic             toggle_prev_q;
  logic             toggle_edge_c;

`ifdef FPU_LINK_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT_CYCLES - 1);
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  assign bus.timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign bus.timeout        = 1'b0;
`endif

  assign toggle_edge_c = (bus.rx_toggle != toggle_prev_q);

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    tx_byte_d   = 8'h00;
    tx_active_d = 1'b0;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
`ifdef FPU_LINK_TIMEOUT_EN
    wait_cnt_d  = '0;
    timeout_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d     = ST_SEND;
          cnt_d       = '0;
          tx_byte_d   = bus.cmd_data[TXW-1 -: 8];
          tx_active_d = 1'b1;
          tx_shift_d  = bus.cmd_data << 8;
        end
      end
      ST_SEND: begin
        if (cnt_q == LAST_TX) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          tx_byte_d   = tx_shift_q[TXW-1 -: 8];
          tx_active_d = 1'b1;
          tx_shift_d  = tx_shift_q << 8;
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (toggle_edge_c) begin
          state_d = ST_RECV;
          cnt_d   = '0;
        end
`ifdef FPU_LINK_TIMEOUT_EN
        else if (wait_cnt_q == LAST_WAIT) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
`endif
      end
      // Further toggle edges here are deliberately ignored.
      ST_RECV: begin
        rx_shift_d = (rx_shift_q << 8) | RXW'(bus.rx_byte);
        if (cnt_q == LAST_RX) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        res_valid_d = 1'b1;
        res_data_d  = rx_shift_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      tx_byte_q     <= 8'h00;
      tx_active_q   <= 1'b0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      toggle_prev_q <= 1'b0;
`ifdef FPU_LINK_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      tx_byte_q     <= tx_byte_d;
      tx_active_q   <= tx_active_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      toggle_prev_q <= bus.rx_toggle;
`ifdef FPU_LINK_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_active = tx_active_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fpu_host_link.sv
// Scoreboard bench for fpu_host_link: expected tx bytes and results are queued when
// stimulus is driven and popped as the link produces them.
module tb_fpu_host_link;
  localparam int unsigned TXB = 16;
  localparam int unsigned RXB = 4;
  localparam int unsigned TO  = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic tgl;

  logic [7:0]  tx_q[$];
  logic [31:0] res_q[$];

  fpu_host_link_if #(.TX_BYTES(TXB), .RX_BYTES(RXB)) bus ();

  fpu_host_link #(.TX_BYTES(TXB), .RX_BYTES(RXB), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_bundle();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Offer a bundle (optionally keeping cmd_valid high) and check every serialised byte.
  task automatic send_frame(input logic [127:0] b, input int flip_at, input bit hold_valid);
    logic [7:0] exp_b;
    bus.cmd_data  = b;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < TXB; i++) tx_q.push_back(b[127-8*i -: 8]);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready got=%b exp=1", bus.cmd_ready);
    end
    step();
    if (!hold_valid) bus.cmd_valid = 1'b0;
    for (int i = 0; i < TXB; i++) begin
      exp_b = tx_q.pop_front();
      checks++;
      if (bus.tx_active !== 1'b1 || bus.tx_byte !== exp_b) begin
        failures++;
        $display("FAIL tx_byte[%0d] got=%h active=%b exp=%h active=1", i, bus.tx_byte, bus.tx_active, exp_b);
      end
      checks++;
      if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin
        failures++;
        $display("FAIL send_status[%0d] got ready=%b busy=%b res_valid=%b exp 0/1/0", i, bus.cmd_ready, bus.busy, bus.res_valid);
      end
      if (i == flip_at) begin
        tgl = ~tgl;
        bus.rx_toggle = tgl;
      end
      if (hold_valid) bus.cmd_data = rand_bundle();
      step();
    end
    checks++;
    if (bus.tx_active !== 1'b0 || bus.tx_byte !== 8'h00 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL send_end got active=%b byte=%h busy=%b exp 0/00/1", bus.tx_active, bus.tx_byte, bus.busy);
    end
  endtask

  // Flip the toggle in WAIT, feed result bytes, check latency and the assembled word.
  task automatic recv_frame(input logic [31:0] r, input int flip_step, input bit tail);
    int lat;
    logic [31:0] exp_r;
    lat = 0;
    res_q.push_back(r);
    tgl = ~tgl;
    bus.rx_toggle = tgl;
    for (int s = 1; s <= 20 && lat == 0; s++) begin
      if (s >= 2 && s <= int'(RXB) + 1) bus.rx_byte = r[31-8*(s-2) -: 8];
      else bus.rx_byte = 8'($urandom());
      if (s == flip_step) begin
        tgl = ~tgl;
        bus.rx_toggle = tgl;
      end
      step();
      if (bus.res_valid === 1'b1) lat = s;
    end
    exp_r = res_q.pop_front();
    checks++;
    if (lat != int'(RXB) + 2) begin
      failures++;
      $display("FAIL recv_latency got=%0d exp=%0d", lat, RXB + 2);
    end
    checks++;
    if (bus.res_data !== exp_r) begin
      failures++;
      $display("FAIL res_data got=%h exp=%h", bus.res_data, exp_r);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL done_status got ready=%b busy=%b exp 1/0", bus.cmd_ready, bus.busy);
    end
    if (tail) begin
      step();
      checks++;
      if (bus.res_valid !== 1'b0 || bus.res_data !== exp_r) begin
        failures++;
        $display("FAIL res_hold got valid=%b data=%h exp 0/%h", bus.res_valid, bus.res_data, exp_r);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.rx_byte   = 8'h00;
    tgl           = 1'b0;
    bus.rx_toggle = 1'b0;
    repeat (2) step();
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.tx_byte !== 8'h00 || bus.tx_active !== 1'b0 ||
        bus.res_valid !== 1'b0 || bus.res_data !== 32'h0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got ready=%b byte=%h act=%b rv=%b rd=%h busy=%b to=%b exp all 0",
               bus.cmd_ready, bus.tx_byte, bus.tx_active, bus.res_valid, bus.res_data, bus.busy, bus.timeout);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got ready=%b busy=%b exp 1/0", bus.cmd_ready, bus.busy);
    end
  endtask

  task automatic test_basic();
    send_frame(128'h40400000_40000000_3F800000_40A00000, -1, 1'b0);
    recv_frame(32'h41500000, 0, 1'b1);
  endtask

  task automatic test_toggle_in_send();
    send_frame(rand_bundle(), 5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0 || bus.tx_active !== 1'b0) begin
        failures++;
        $display("FAIL wait_idle[%0d] got busy=%b rv=%b act=%b exp 1/0/0", i, bus.busy, bus.res_valid, bus.tx_active);
      end
    end
    recv_frame($urandom(), 0, 1'b1);
  endtask

  task automatic test_toggle_in_recv();
    send_frame(rand_bundle(), -1, 1'b0);
    recv_frame($urandom(), 3, 1'b1);
  endtask

  task automatic test_reset_mid_send();
    logic [127:0] b;
    b = rand_bundle();
    bus.cmd_data  = b;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    repeat (7) step();
    checks++;
    if (bus.tx_byte !== b[127-8*7 -: 8] || bus.tx_active !== 1'b1) begin
      failures++;
      $display("FAIL byte7 got=%h act=%b exp=%h act=1", bus.tx_byte, bus.tx_active, b[127-8*7 -: 8]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.tx_byte !== 8'h00 || bus.tx_active !== 1'b0 ||
        bus.res_valid !== 1'b0 || bus.res_data !== 32'h0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got ready=%b byte=%h act=%b rv=%b rd=%h busy=%b to=%b exp all 0",
               bus.cmd_ready, bus.tx_byte, bus.tx_active, bus.res_valid, bus.res_data, bus.busy, bus.timeout);
    end
    tx_q.delete();
    step();
    rst_n = 1'b1;
    step();
    send_frame(rand_bundle(), -1, 1'b0);
    recv_frame($urandom(), 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      send_frame(rand_bundle(), -1, 1'b1);
      recv_frame($urandom(), 0, 1'b0);
    end
    bus.cmd_valid = 1'b0;
    step();
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.tx_active !== 1'b0 || bus.res_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got ready=%b busy=%b act=%b rv=%b exp 1/0/0/0", bus.cmd_ready, bus.busy, bus.tx_active, bus.res_valid);
    end
  endtask

  task automatic test_timeout();
    int lat;
    bit seen_rv;
    lat = 0;
    seen_rv = 1'b0;
    send_frame(rand_bundle(), -1, 1'b0);
`ifdef FPU_LINK_TIMEOUT_EN
    for (int s = 1; s <= 50 && lat == 0; s++) begin
      step();
      if (bus.res_valid === 1'b1) seen_rv = 1'b1;
      if (bus.timeout === 1'b1) lat = s;
    end
    checks++;
    if (lat != int'(TO)) begin
      failures++;
      $display("FAIL timeout_latency got=%0d exp=%0d", lat, TO);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || seen_rv) begin
      failures++;
      $display("FAIL timeout_state got ready=%b busy=%b rv_seen=%b exp 1/0/0", bus.cmd_ready, bus.busy, seen_rv);
    end
    step();
    checks++;
    if (bus.timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse got=%b exp=0", bus.timeout);
    end
`else
    for (int s = 1; s <= 30; s++) begin
      step();
      if (bus.timeout !== 1'b0) lat = s;
      if (bus.res_valid !== 1'b0) seen_rv = 1'b1;
    end
    checks++;
    if (lat != 0 || seen_rv || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL wait_forever got to_at=%0d rv_seen=%b busy=%b exp 0/0/1", lat, seen_rv, bus.busy);
    end
    recv_frame($urandom(), 0, 1'b1);
`endif
  endtask

  initial begin
    clk      = 1'b0;
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_toggle_in_send();
    test_toggle_in_recv();
    test_reset_mid_send();
    test_back_to_back();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
